// File: rtl/sysid_boot_checker.sv
// rtl/sysid_boot_checker.sv - Avalon-MM reader that verifies system ID and build timestamp; optional retry via SYSID_CHECK_RETRY_EN
module sysid_boot_checker #(
    parameter logic [31:0] EXPECTED_ID        = 32'hAAAAAAAA,
    parameter logic [31:0] EXPECTED_TIMESTAMP = 32'h5373265F,
    parameter int          READ_LATENCY       = 0,
    parameter int          TIMEOUT_CYCLES     = 255,
    parameter int          AUTO_START         = 1,
    parameter int          MAX_RETRIES        = 3
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    output logic        avm_address,
    output logic        avm_read,
    input  logic        avm_waitrequest,
    input  logic [31:0] avm_readdata,
    output logic        busy,
    output logic        done,
    output logic        id_ok,
    output logic        ts_ok,
    output logic        timeout,
    output logic [31:0] id_value,
    output logic [31:0] ts_value
);

    if (READ_LATENCY < 0 || READ_LATENCY > 3) begin : g_bad_latency
        $error("READ_LATENCY must be 0..3");
    end
    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be 1..65535");
    end
    if (MAX_RETRIES < 0 || MAX_RETRIES > 3) begin : g_bad_retries
        $error("MAX_RETRIES must be 0..3");
    end

    localparam logic [15:0] WAIT_LIMIT = 16'(TIMEOUT_CYCLES - 1);
    localparam logic [1:0]  LAT_LAST   = 2'(READ_LATENCY - 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        RD_ID  = 3'd1,
        LAT_ID = 3'd2,
        RD_TS  = 3'd3,
        LAT_TS = 3'd4,
        CHECK  = 3'd5
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic        first_cycle;
    logic [15:0] wait_cnt;
    logic [1:0]  lat_cnt;
    logic        in_read;
    logic        accept;
    logic        wait_expired;
    logic        lat_last;
    logic        id_match;
    logic        ts_match;
    logic        enter_read;
    logic        retry_go;

    assign in_read      = (state == RD_ID) || (state == RD_TS);
    assign accept       = in_read && !avm_waitrequest;
    assign wait_expired = in_read && avm_waitrequest && (wait_cnt == WAIT_LIMIT);
    assign lat_last     = (lat_cnt == LAT_LAST);
    assign id_match     = (id_value == EXPECTED_ID);
    assign ts_match     = (ts_value == EXPECTED_TIMESTAMP);
    assign enter_read   = ((state_nxt == RD_ID) && (state != RD_ID)) ||
                          ((state_nxt == RD_TS) && (state != RD_TS));

`ifdef SYSID_CHECK_RETRY_EN
    logic [1:0] retries;

    assign retry_go = (state == CHECK) && !(id_match && ts_match) &&
                      ({30'd0, retries} < MAX_RETRIES);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            retries <= 2'd0;
        end else if (state == IDLE && state_nxt == RD_ID) begin
            retries <= 2'd0;
        end else if (retry_go) begin
            retries <= retries + 2'd1;
        end
    end
`else
    assign retry_go = 1'b0;
`endif

    // Bus strobes and done are decoded from state so reset drops them at once.
    always_comb begin
        state_nxt   = state;
        avm_read    = 1'b0;
        avm_address = 1'b0;
        done        = 1'b0;
        case (state)
            IDLE: begin
                if (start || (AUTO_START != 0 && first_cycle)) begin
                    state_nxt = RD_ID;
                end
            end
            RD_ID: begin
                avm_read = 1'b1;
                if (wait_expired) begin
                    done      = 1'b1;
                    state_nxt = IDLE;
                end else if (accept) begin
                    state_nxt = (READ_LATENCY == 0) ? RD_TS : LAT_ID;
                end
            end
            LAT_ID: begin
                if (lat_last) begin
                    state_nxt = RD_TS;
                end
            end
            RD_TS: begin
                avm_read    = 1'b1;
                avm_address = 1'b1;
                if (wait_expired) begin
                    done      = 1'b1;
                    state_nxt = IDLE;
                end else if (accept) begin
                    state_nxt = (READ_LATENCY == 0) ? CHECK : LAT_TS;
                end
            end
            LAT_TS: begin
                avm_address = 1'b1;
                if (lat_last) begin
                    state_nxt = CHECK;
                end
            end
            CHECK: begin
                if (retry_go) begin
                    state_nxt = RD_ID;
                end else begin
                    done      = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            first_cycle <= 1'b1;
            wait_cnt    <= 16'd0;
            lat_cnt     <= 2'd0;
            busy        <= 1'b0;
            id_ok       <= 1'b0;
            ts_ok       <= 1'b0;
            timeout     <= 1'b0;
            id_value    <= 32'd0;
            ts_value    <= 32'd0;
        end else begin
            state       <= state_nxt;
            first_cycle <= 1'b0;

            if (enter_read) begin
                wait_cnt <= 16'd0;
            end else if (in_read && avm_waitrequest) begin
                wait_cnt <= wait_cnt + 16'd1;
            end

            if (state == LAT_ID || state == LAT_TS) begin
                lat_cnt <= lat_cnt + 2'd1;
            end else begin
                lat_cnt <= 2'd0;
            end

            if (state_nxt == RD_ID && state != RD_ID) begin
                busy    <= 1'b1;
                id_ok   <= 1'b0;
                ts_ok   <= 1'b0;
                timeout <= 1'b0;
            end

            if ((state == RD_ID && accept && READ_LATENCY == 0) ||
                (state == LAT_ID && lat_last)) begin
                id_value <= avm_readdata;
            end
            if ((state == RD_TS && accept && READ_LATENCY == 0) ||
                (state == LAT_TS && lat_last)) begin
                ts_value <= avm_readdata;
            end

            if (wait_expired) begin
                timeout <= 1'b1;
                busy    <= 1'b0;
            end

            if (state == CHECK && !retry_go) begin
                id_ok <= id_match;
                ts_ok <= ts_match;
                busy  <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_sysid_boot_checker.sv
// tb/tb_sysid_boot_checker.sv - directed self-checking bench for sysid_boot_checker
module tb_sysid_boot_checker;

    localparam logic [31:0] ID_WORD = 32'hAAAAAAAA;
    localparam logic [31:0] TS_WORD = 32'h5373265F;

    logic clock;
    logic reset;
    int   tests;
    int   fails;

    // instance a: defaults, zero-wait slave
    logic        start_a, addr_a, read_a, wait_a, busy_a, done_a, id_ok_a, ts_ok_a, timeout_a;
    logic [31:0] rdata_a, id_value_a, ts_value_a, id_word_a;
    // instance b: latency 2, five stall cycles per read
    logic        start_b, addr_b, read_b, wait_b, busy_b, done_b, id_ok_b, ts_ok_b, timeout_b;
    logic [31:0] rdata_b, id_value_b, ts_value_b;
    // instance c: timeout 10, slave stuck in waitrequest
    logic        start_c, addr_c, read_c, wait_c, busy_c, done_c, id_ok_c, ts_ok_c, timeout_c;
    logic [31:0] rdata_c, id_value_c, ts_value_c;

    sysid_boot_checker dut_a (
        .clock(clock), .reset(reset), .start(start_a),
        .avm_address(addr_a), .avm_read(read_a), .avm_waitrequest(wait_a), .avm_readdata(rdata_a),
        .busy(busy_a), .done(done_a), .id_ok(id_ok_a), .ts_ok(ts_ok_a), .timeout(timeout_a),
        .id_value(id_value_a), .ts_value(ts_value_a)
    );

    sysid_boot_checker #(.READ_LATENCY(2), .AUTO_START(0)) dut_b (
        .clock(clock), .reset(reset), .start(start_b),
        .avm_address(addr_b), .avm_read(read_b), .avm_waitrequest(wait_b), .avm_readdata(rdata_b),
        .busy(busy_b), .done(done_b), .id_ok(id_ok_b), .ts_ok(ts_ok_b), .timeout(timeout_b),
        .id_value(id_value_b), .ts_value(ts_value_b)
    );

    sysid_boot_checker #(.TIMEOUT_CYCLES(10), .AUTO_START(0)) dut_c (
        .clock(clock), .reset(reset), .start(start_c),
        .avm_address(addr_c), .avm_read(read_c), .avm_waitrequest(wait_c), .avm_readdata(rdata_c),
        .busy(busy_c), .done(done_c), .id_ok(id_ok_c), .ts_ok(ts_ok_c), .timeout(timeout_c),
        .id_value(id_value_c), .ts_value(ts_value_c)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    assign wait_a  = 1'b0;
    assign rdata_a = addr_a ? TS_WORD : id_word_a;

    // Slave b: stall five cycles, then return data exactly two cycles after acceptance.
    int   stall_b;
    logic v1_b, v2_b, a1_b, a2_b;
    assign wait_b  = read_b && (stall_b < 5);
    assign rdata_b = v2_b ? (a2_b ? TS_WORD : ID_WORD) : 32'hDEADBEEF;

    always @(posedge clock or posedge reset) begin
        if (reset) begin
            stall_b <= 0;
            v1_b <= 1'b0; v2_b <= 1'b0; a1_b <= 1'b0; a2_b <= 1'b0;
        end else begin
            if (read_b) stall_b <= wait_b ? stall_b + 1 : 0;
            v1_b <= read_b && !wait_b;
            a1_b <= addr_b;
            v2_b <= v1_b;
            a2_b <= a1_b;
        end
    end

    assign wait_c  = 1'b1;
    assign rdata_c = 32'h0;

    int   done_cnt_a, done_cnt_b, done_cnt_c, acc_a, acc_b, rdcyc_c, viol_b;
    logic prev_stall_b, prev_addr_b;

    initial begin
        done_cnt_a = 0; done_cnt_b = 0; done_cnt_c = 0;
        acc_a = 0; acc_b = 0; rdcyc_c = 0; viol_b = 0;
        prev_stall_b = 1'b0; prev_addr_b = 1'b0;
    end

    always @(posedge clock) begin
        if (done_a) done_cnt_a <= done_cnt_a + 1;
        if (done_b) done_cnt_b <= done_cnt_b + 1;
        if (done_c) done_cnt_c <= done_cnt_c + 1;
        if (read_a && !wait_a) acc_a <= acc_a + 1;
        if (read_b && !wait_b) acc_b <= acc_b + 1;
        if (read_c) rdcyc_c <= rdcyc_c + 1;
        if (!reset && prev_stall_b && (!read_b || addr_b != prev_addr_b)) viol_b <= viol_b + 1;
        prev_stall_b <= read_b && wait_b;
        prev_addr_b  <= addr_b;
    end

    task automatic test_reset;
        repeat (3) @(negedge clock);
        tests++;
        if ({read_a, addr_a, busy_a, done_a, id_ok_a, ts_ok_a, timeout_a} !== 7'b0) begin
            fails++;
            $display("FAIL reset_ctrl: got %b expected 0000000",
                     {read_a, addr_a, busy_a, done_a, id_ok_a, ts_ok_a, timeout_a});
        end
        tests++;
        if ({id_value_a, ts_value_a} !== 64'h0) begin
            fails++;
            $display("FAIL reset_values: got %h/%h expected 0/0", id_value_a, ts_value_a);
        end
    endtask

    task automatic test_auto_start;
        int got;
        got = 0;
        reset = 1'b0;
        for (int c = 1; c <= 12; c++) begin
            @(negedge clock);
            if (done_a && got == 0) got = c;
        end
        tests++;
        if (got != 3) begin
            fails++;
            $display("FAIL auto_done_cycle: got %0d expected 3", got);
        end
        tests++;
        if ({id_ok_a, ts_ok_a, timeout_a, busy_a} !== 4'b1100) begin
            fails++;
            $display("FAIL auto_status: got %b expected 1100", {id_ok_a, ts_ok_a, timeout_a, busy_a});
        end
        tests++;
        if (id_value_a !== ID_WORD || ts_value_a !== TS_WORD) begin
            fails++;
            $display("FAIL auto_values: got %h/%h expected %h/%h", id_value_a, ts_value_a, ID_WORD, TS_WORD);
        end
        tests++;
        if (busy_b !== 1'b0 || busy_c !== 1'b0) begin
            fails++;
            $display("FAIL no_auto_start: got busy_b=%b busy_c=%b expected 0/0", busy_b, busy_c);
        end
    endtask

    task automatic test_latency_stall;
        int got, d0, a0, v0;
        got = 0;
        d0 = done_cnt_b; a0 = acc_b; v0 = viol_b;
        start_b = 1'b1;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clock);
            start_b = (c == 5);
            if (done_b && got == 0) got = c;
        end
        start_b = 1'b0;
        tests++;
        if (got != 17) begin
            fails++;
            $display("FAIL stall_done_cycle: got %0d expected 17", got);
        end
        tests++;
        if (done_cnt_b - d0 != 1) begin
            fails++;
            $display("FAIL busy_start_ignored: got %0d done pulses expected 1", done_cnt_b - d0);
        end
        tests++;
        if (viol_b != v0) begin
            fails++;
            $display("FAIL stall_stable: got %0d violations expected 0", viol_b - v0);
        end
        tests++;
        if (acc_b - a0 != 2) begin
            fails++;
            $display("FAIL stall_reads: got %0d accepted reads expected 2", acc_b - a0);
        end
        tests++;
        if ({id_ok_b, ts_ok_b, timeout_b, busy_b} !== 4'b1100 || id_value_b !== ID_WORD || ts_value_b !== TS_WORD) begin
            fails++;
            $display("FAIL stall_status: got %b %h/%h expected 1100 %h/%h",
                     {id_ok_b, ts_ok_b, timeout_b, busy_b}, id_value_b, ts_value_b, ID_WORD, TS_WORD);
        end
    endtask

    task automatic test_id_mismatch;
        int got, d0, a0, exp_cyc, exp_acc;
`ifdef SYSID_CHECK_RETRY_EN
        exp_cyc = 12; exp_acc = 8;
`else
        exp_cyc = 3;  exp_acc = 2;
`endif
        got = 0;
        d0 = done_cnt_a; a0 = acc_a;
        id_word_a = 32'h12345678;
        start_a = 1'b1;
        for (int c = 1; c <= 30; c++) begin
            @(negedge clock);
            start_a = 1'b0;
            if (done_a && got == 0) got = c;
        end
        tests++;
        if (got != exp_cyc) begin
            fails++;
            $display("FAIL mismatch_done_cycle: got %0d expected %0d", got, exp_cyc);
        end
        tests++;
        if (done_cnt_a - d0 != 1 || acc_a - a0 != exp_acc) begin
            fails++;
            $display("FAIL mismatch_counts: got done=%0d reads=%0d expected 1/%0d",
                     done_cnt_a - d0, acc_a - a0, exp_acc);
        end
        tests++;
        if ({id_ok_a, ts_ok_a, timeout_a} !== 3'b010 || id_value_a !== 32'h12345678) begin
            fails++;
            $display("FAIL mismatch_status: got %b %h expected 010 12345678",
                     {id_ok_a, ts_ok_a, timeout_a}, id_value_a);
        end
        id_word_a = ID_WORD;
    endtask

    task automatic test_timeout;
        int got, d0, r0;
        got = 0;
        d0 = done_cnt_c; r0 = rdcyc_c;
        start_c = 1'b1;
        for (int c = 1; c <= 30; c++) begin
            @(negedge clock);
            start_c = 1'b0;
            if (done_c && got == 0) got = c;
        end
        tests++;
        if (got != 10) begin
            fails++;
            $display("FAIL timeout_done_cycle: got %0d expected 10", got);
        end
        tests++;
        if (rdcyc_c - r0 != 10 || done_cnt_c - d0 != 1) begin
            fails++;
            $display("FAIL timeout_counts: got read_cycles=%0d done=%0d expected 10/1",
                     rdcyc_c - r0, done_cnt_c - d0);
        end
        tests++;
        if ({timeout_c, id_ok_c, ts_ok_c, busy_c, read_c} !== 5'b10000) begin
            fails++;
            $display("FAIL timeout_status: got %b expected 10000", {timeout_c, id_ok_c, ts_ok_c, busy_c, read_c});
        end
    endtask

    task automatic test_reset_mid_read;
        int d0;
        logic found;
        found = 1'b0;
        d0 = done_cnt_b;
        start_b = 1'b1;
        for (int c = 1; c <= 40 && !found; c++) begin
            @(negedge clock);
            start_b = 1'b0;
            if (read_b && addr_b) found = 1'b1;
        end
        tests++;
        if (!found) begin
            fails++;
            $display("FAIL reach_rd_ts: got no timestamp read within 40 cycles expected one");
        end
        #2 reset = 1'b1;
        #1;
        tests++;
        if ({read_b, addr_b, busy_b, done_b, id_ok_b, ts_ok_b, timeout_b} !== 7'b0 ||
            {id_value_b, ts_value_b} !== 64'h0) begin
            fails++;
            $display("FAIL async_reset_outputs: got %b %h/%h expected 0000000 0/0",
                     {read_b, addr_b, busy_b, done_b, id_ok_b, ts_ok_b, timeout_b}, id_value_b, ts_value_b);
        end
        repeat (3) @(negedge clock);
        tests++;
        if (done_cnt_b != d0) begin
            fails++;
            $display("FAIL reset_no_done: got %0d done pulses expected 0", done_cnt_b - d0);
        end
        reset = 1'b0;
        repeat (2) @(negedge clock);
    endtask

    initial begin
        tests = 0; fails = 0;
        reset = 1'b1;
        start_a = 1'b0; start_b = 1'b0; start_c = 1'b0;
        id_word_a = ID_WORD;
        test_reset();
        test_auto_start();
        test_latency_stall();
        test_id_mismatch();
        test_timeout();
        test_reset_mid_read();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
